// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with sequential bulk clear.
// Define REGFILE_BYPASS_EN to forward an accepted write to same-cycle reads.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NRD = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    output logic                wr_ready_o,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic                clr_req_i,
    output logic                clr_busy_o,
    output logic                clr_done_o
);
    localparam logic IDLE = 1'b0;
    localparam logic CLEAR = 1'b1;
    logic            state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic            wr_fire;
    logic            last;
    assign clr_busy_o = state == CLEAR;
    assign wr_ready_o = !clr_busy_o;
    assign wr_fire = wr_en_i && wr_ready_o && !(ZERO_REG != 0 && wr_addr_i == '0);
    assign last = cnt == AW'(NREGS - 1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            clr_done_o <= 1'b0;
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            clr_done_o <= 1'b0;
            if (state == IDLE) begin
                // a write sampled with a clear request lands first, then gets erased
                if (wr_fire) mem[wr_addr_i] <= wr_data_i;
                if (clr_req_i) begin
                    state <= CLEAR;
                    cnt <= '0;
                end
            end else begin
                mem[cnt] <= '0;
                cnt <= last ? '0 : cnt + AW'(1);
                if (last) begin
                    state <= IDLE;
                    clr_done_o <= 1'b1;
                end
            end
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a = rd_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_fire && a == wr_addr_i;
`else
        assign hit = 1'b0;
`endif
        assign rd_data_o[k*XLEN +: XLEN] = (clr_busy_o || (ZERO_REG != 0 && a == '0)) ? '0 :
                                           hit ? wr_data_i : mem[a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp against a behavioural model.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    logic wr_en, clr_req, wr_ready, busy, done;
    logic [4:0] wr_addr;
    logic [31:0] wr_data;
    logic [9:0] rd_addr;
    logic [63:0] rd_data;
    logic w2_en, clr2, ready2, busy2, done2;
    logic [3:0] w2_addr;
    logic [63:0] w2_data;
    logic [11:0] r2_addr;
    logic [191:0] r2_data;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_mem [32];
    int m_left;
    logic m_done;
    int busy_cycles, done_cnt;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .clr_req_i(clr_req),
        .clr_busy_o(busy), .clr_done_o(done)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(w2_en), .wr_addr_i(w2_addr), .wr_data_i(w2_data),
        .wr_ready_o(ready2), .rd_addr_i(r2_addr), .rd_data_o(r2_data), .clr_req_i(clr2),
        .clr_busy_o(busy2), .clr_done_o(done2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clearing is unobservable until it ends (reads masked, writes dropped),
    // so the model zeroes everything at the request and only counts cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_left <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= m_left == 1;
            if (m_left > 0) m_left <= m_left - 1;
            else if (clr_req) begin
                m_left <= 32;
                for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            end else if (wr_en && wr_addr != 0) m_mem[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        logic [4:0] a;
        logic [31:0] e;
        logic acc;
        acc = wr_en && m_left == 0 && wr_addr != 0;
        chk("busy", busy, m_left != 0);
        chk("ready", wr_ready, m_left == 0);
        chk("done", done, m_done);
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            e = m_mem[a];
`ifdef REGFILE_BYPASS_EN
            if (acc && a == wr_addr) e = wr_data;
`endif
            if (m_left != 0 || a == 0) e = '0;
            chk($sformatf("rd%0d", k), rd_data[k*32 +: 32], e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; clr_req = 0;
        w2_en = 0; w2_addr = 0; w2_data = 0; r2_addr = 0; clr2 = 0;
        rst = 0;
        #1 rst = 1;
        #12 rst = 0;
        tick();
        chk("rst_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(i), 5'(i)};
            #1 chk("rst_read", rd_data, 64'h0);
            tick();
        end
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0; rd_addr = {5'd5, 5'd0};
        #1 chk("x5_port1", rd_data[63:32], 64'hDEADBEEF);
        tick();
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        tick();
        wr_en = 0; rd_addr = 0;
        #1 chk("x0_read", rd_data[31:0], 64'h0);
        tick();
        wr_en = 1; wr_addr = 7; wr_data = 32'hCAFEF00D; rd_addr = {5'd0, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_same", rd_data[31:0], 64'hCAFEF00D);
`else
        chk("x7_same", rd_data[31:0], 64'h0);
`endif
        tick();
        wr_en = 0;
        #1 chk("x7_next", rd_data[31:0], 64'hCAFEF00D);
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_en = 0; rd_addr = {5'd31, 5'd12};
        #1 chk("fill_x12", rd_data[31:0], 64'd12);
        chk("fill_x31", rd_data[63:32], 64'd31);
        rd_addr = {5'd9, 5'd20};
        clr_req = 1;
        tick();
        clr_req = 0;
        busy_cycles = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) begin
                wr_en = 1; wr_addr = 9; wr_data = 32'h55;
            end else wr_en = 0;
            #1;
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            tick();
        end
        wr_en = 0;
        chk("clr_cycles", 64'(busy_cycles), 64'd32);
        chk("clr_done_cnt", 64'(done_cnt), 64'd1);
        #1 chk("clr_x9", rd_data[63:32], 64'h0);
        chk("clr_x20", rd_data[31:0], 64'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            tick();
        end
        wr_en = 1; wr_addr = 3; wr_data = 32'h33;
        tick();
        wr_en = 0;
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (9) tick();
        #2 rst = 1;
        #1 chk("abort_busy", busy, 0);
        chk("abort_ready", wr_ready, 1);
        #2 rst = 0;
        done_cnt = 0;
        rd_addr = {5'd3, 5'd3};
        for (int c = 0; c < 40; c++) begin
            #1 if (done) done_cnt++;
            tick();
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_x3", rd_data, 64'h0);
        w2_en = 1; w2_addr = 3; w2_data = 64'hA5A5A5A5A5A5A5A5;
        tick();
        w2_addr = 15; w2_data = 64'h1;
        tick();
        w2_en = 0; r2_addr = {4'd15, 4'd3, 4'd3};
        #1 chk("p3_rd0", r2_data[63:0], 64'hA5A5A5A5A5A5A5A5);
        chk("p3_rd1", r2_data[127:64], 64'hA5A5A5A5A5A5A5A5);
        chk("p3_rd2", r2_data[191:128], 64'h1);
        clr2 = 1;
        tick();
        clr2 = 0;
        busy_cycles = 0; done_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (busy2) busy_cycles++;
            if (done2) done_cnt++;
            tick();
        end
        chk("p3_clr_cycles", 64'(busy_cycles), 64'd16);
        chk("p3_clr_done", 64'(done_cnt), 64'd1);
        #1 chk("p3_after_clr", r2_data[191:128], 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
